sdram_arbiter: RTL and testbench

- Shares the single SDRAM controller user port between two requesters:
  - port 0: the 6502 CPU bus path;
  - port 1: the auxiliary path (UART loader / debug, segment-display readback).
- Also schedules periodic auto-refresh requests to the controller.
- Sits between the apple1 core address decode and the SDRAM controller; runs on clk25.

---
 rtl/sdram_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port between the CPU (m0) and aux (m1) paths and injects periodic refresh.
// Latency: request seen in IDLE -> ctl_req next cycle; mN_ack one cycle after ctl_ack (or after TIMEOUT_CYCLES).
// Backpressure: requesters hold req until ack; ARB_FIXED_PRIO_EN selects CPU-priority with m1 anti-starvation.
module sdram_arbiter #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 8,
    parameter int REFRESH_CYCLES = 390,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk25,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ctl_req,
    output logic              ctl_we,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [DATA_W-1:0] ctl_wdata,
    input  logic              ctl_ack,
    input  logic [DATA_W-1:0] ctl_rdata,
    output logic              ctl_ref,
    input  logic              ctl_ref_ack,
    output logic              timeout_err
);
    localparam int RW = $clog2(REFRESH_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, REFRESH} state_t;

    state_t          state, state_nxt;
    logic [RW-1:0]   ref_cnt;
    logic            ref_pend;
    logic            ref_wrap;
    logic [TW-1:0]   wd;
    logic            wd_expire;
    logic            last_grant;
    logic            pick0, pick1;
    logic            grant0, grant1, enter_ref;
    logic            done0, done1, tmo0, tmo1, tmo_ref;

`ifdef ARB_FIXED_PRIO_EN
    logic [3:0]      starve_cnt;
`endif

    assign ref_wrap  = (ref_cnt == RW'(REFRESH_CYCLES - 1));
    assign wd_expire = (wd == TW'(TIMEOUT_CYCLES - 1));

    // A wrap while a refresh is already pending is absorbed, not queued.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt  <= '0;
            ref_pend <= 1'b0;
        end else begin
            ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
            if (enter_ref)
                ref_pend <= 1'b0;
            else if (ref_wrap)
                ref_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        pick1     = 1'b0;
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        enter_ref = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
        tmo0      = 1'b0;
        tmo1      = 1'b0;
        tmo_ref   = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        pick1 = m1_req && (!m0_req || (starve_cnt == 4'd15));
`else
        pick1 = m1_req && (!m0_req || !last_grant);
`endif
        pick0 = m0_req && !pick1;

        case (state)
            IDLE: begin
                if (ref_pend) begin
                    state_nxt = REFRESH;
                    enter_ref = 1'b1;
                end else if (pick0) begin
                    state_nxt = GRANT0;
                    grant0    = 1'b1;
                end else if (pick1) begin
                    state_nxt = GRANT1;
                    grant1    = 1'b1;
                end
            end
            GRANT0: begin
                if (ctl_ack) begin
                    done0     = 1'b1;
                    state_nxt = IDLE;
                end else if (wd_expire) begin
                    tmo0      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            GRANT1: begin
                if (ctl_ack) begin
                    done1     = 1'b1;
                    state_nxt = IDLE;
                end else if (wd_expire) begin
                    tmo1      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            REFRESH: begin
                if (ctl_ref_ack) begin
                    state_nxt = IDLE;
                end else if (wd_expire) begin
                    tmo_ref   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ctl_req/ctl_ref follow the next state, so both drop in IDLE and never overlap.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            ctl_req     <= 1'b0;
            ctl_ref     <= 1'b0;
            ctl_we      <= 1'b0;
            ctl_addr    <= '0;
            ctl_wdata   <= '0;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
            timeout_err <= 1'b0;
            last_grant  <= 1'b1;
            wd          <= '0;
        end else begin
            ctl_req <= (state_nxt == GRANT0) || (state_nxt == GRANT1);
            ctl_ref <= (state_nxt == REFRESH);
            m0_ack  <= done0 | tmo0;
            m1_ack  <= done1 | tmo1;

            if (grant0) begin
                ctl_we     <= m0_we;
                ctl_addr   <= m0_addr;
                ctl_wdata  <= m0_wdata;
                last_grant <= 1'b0;
            end else if (grant1) begin
                ctl_we     <= m1_we;
                ctl_addr   <= m1_addr;
                ctl_wdata  <= m1_wdata;
                last_grant <= 1'b1;
            end

            if (done0)
                m0_rdata <= ctl_rdata;
            else if (tmo0)
                m0_rdata <= '1;

            if (done1)
                m1_rdata <= ctl_rdata;
            else if (tmo1)
                m1_rdata <= '1;

            if (tmo0 || tmo1 || tmo_ref)
                timeout_err <= 1'b1;

            wd <= ((state == IDLE) || (state_nxt == IDLE)) ? '0 : wd + 1'b1;
        end
    end

`ifdef ARB_FIXED_PRIO_EN
    // Counts CPU wins taken while m1 waits; saturation hands the next slot to m1.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= 4'd0;
        else if (grant1)
            starve_cnt <= 4'd0;
        else if (grant0 && m1_req && (starve_cnt != 4'd15))
            starve_cnt <= starve_cnt + 4'd1;
    end
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus a randomized traffic run against a memory model.
module tb_sdram_arbiter;
    logic        clk25 = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
    logic [15:0] m0_addr, m1_addr, ctl_addr;
    logic [7:0]  m0_wdata, m1_wdata, m0_rdata, m1_rdata, ctl_wdata, ctl_rdata;
    logic        ctl_req, ctl_we, ctl_ack, ctl_ref, ctl_ref_ack, timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    always #20 clk25 = ~clk25;

    sdram_arbiter dut (
        .clk25(clk25), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ctl_req(ctl_req), .ctl_we(ctl_we), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
        .ctl_ack(ctl_ack), .ctl_rdata(ctl_rdata),
        .ctl_ref(ctl_ref), .ctl_ref_ack(ctl_ref_ack), .timeout_err(timeout_err)
    );

    // Controller model: memory with programmable ack latency.
    logic [7:0] mem [0:65535];
    bit ack_en, rand_lat;
    int ctl_lat, ref_lat, req_age, ref_age, cyc;
    bit acked;

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));
        mem[16'h0300] = 8'h5A;
        ctl_ack = 1'b0; ctl_ref_ack = 1'b0; ctl_rdata = 8'h00;
        req_age = 0; ref_age = 0; acked = 1'b0;
        forever begin
            @(posedge clk25); #1;
            ctl_ack = 1'b0;
            ctl_ref_ack = 1'b0;
            if (ctl_req) begin
                req_age++;
                if (ack_en && !acked && req_age >= ctl_lat) begin
                    ctl_ack = 1'b1;
                    acked = 1'b1;
                    if (ctl_we) mem[ctl_addr] = ctl_wdata;
                    else ctl_rdata = mem[ctl_addr];
                    if (rand_lat) ctl_lat = $urandom_range(1, 4);
                end
            end else begin
                req_age = 0;
                acked = 1'b0;
            end
            if (ctl_ref) begin
                ref_age++;
                if (ref_age == ref_lat) ctl_ref_ack = 1'b1;
            end else begin
                ref_age = 0;
            end
        end
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk25);
            cyc = rst_n ? cyc + 1 : 0;
        end
    end

    initial begin
        #4000000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int p, input logic r, input logic w, input logic [15:0] a, input logic [7:0] d);
        if (p == 0) begin
            m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d;
        end
    endtask

    task automatic chk_zero_outs(input string pfx);
        chk({pfx, "_ctl_req"}, ctl_req, 0);
        chk({pfx, "_ctl_ref"}, ctl_ref, 0);
        chk({pfx, "_ctl_we"}, ctl_we, 0);
        chk({pfx, "_ctl_addr"}, ctl_addr, 0);
        chk({pfx, "_ctl_wdata"}, ctl_wdata, 0);
        chk({pfx, "_m0_ack"}, m0_ack, 0);
        chk({pfx, "_m1_ack"}, m1_ack, 0);
        chk({pfx, "_m0_rdata"}, m0_rdata, 0);
        chk({pfx, "_m1_rdata"}, m1_rdata, 0);
        chk({pfx, "_timeout_err"}, timeout_err, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk25);
        @(negedge clk25);
        rst_n = 1'b1;
    endtask

    // Expected owner of the n-th grant when both requesters stay busy (1 = m1).
    function automatic logic exp_grant(input int n);
`ifdef ARB_FIXED_PRIO_EN
        return (n % 16) == 15;
`else
        return (n % 2) == 1;
`endif
    endfunction

    logic [7:0] ref_mem [logic [15:0]];

    function automatic logic [7:0] model_rd(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    int k, n, ng, ref_rises, done_cnt;
    bit prev_req, prev_ack, prev_ref, a0prev, a1prev, seen;
    int busy [2];
    logic pwe [2];
    logic [15:0] pa [2];
    logic [7:0] pd [2], pexp [2];
    logic ak;
    logic [7:0] rd;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 16'h0, 8'h0);
        drive(1, 0, 0, 16'h0, 8'h0);
        ack_en = 1'b1; rand_lat = 1'b0; ctl_lat = 3; ref_lat = 2;
        repeat (3) @(negedge clk25);
        chk_zero_outs("reset");
        rst_n = 1'b1;

        // Single read with a 3-cycle controller.
        drive(0, 1, 0, 16'h0300, 8'h00);
        for (k = 0; k < 10 && !ctl_req; k++) @(negedge clk25);
        chk("rd_ctl_req", ctl_req, 1);
        chk("rd_addr", ctl_addr, 16'h0300);
        chk("rd_we", ctl_we, 0);
        for (k = 0; k < 20 && !ctl_ack; k++) @(negedge clk25);
        chk("rd_ctl_ack", ctl_ack, 1);
        chk("rd_ack_early", m0_ack, 0);
        @(negedge clk25);
        chk("rd_ack", m0_ack, 1);
        chk("rd_data", m0_rdata, 8'h5A);
        chk("rd_m1_ack", m1_ack, 0);
        drive(0, 0, 0, 16'h0, 8'h0);
        @(negedge clk25);
        chk("rd_ack_width", m0_ack, 0);
        chk("rd_req_drop", ctl_req, 0);

        // Contention: both held from reset.
        rst_n = 1'b0;
        drive(0, 1, 0, 16'h0100, 8'h00);
        drive(1, 1, 0, 16'h0200, 8'h00);
        ctl_lat = 1;
        @(negedge clk25);
        rst_n = 1'b1;
        ng = 0; prev_req = 0; prev_ack = 0; a0prev = 0; a1prev = 0;
        for (int c = 0; c < 300 && ng < 32; c++) begin
            @(negedge clk25);
            if (ctl_req && !prev_req) begin
                chk("grant_order", ctl_addr, exp_grant(ng) ? 16'h0200 : 16'h0100);
                ng++;
            end
            if (prev_req && prev_ack) chk("cont_gap", ctl_req, 0);
            if (a0prev) chk("cont_ack0_width", m0_ack, 0);
            if (a1prev) chk("cont_ack1_width", m1_ack, 0);
            if (m0_ack) chk("cont_rd0", m0_rdata, init_val(16'h0100));
            if (m1_ack) chk("cont_rd1", m1_rdata, init_val(16'h0200));
            prev_req = ctl_req; prev_ack = ctl_ack; a0prev = m0_ack; a1prev = m1_ack;
        end
        chk("cont_grants", ng, 32);
        drive(0, 0, 0, 16'h0, 8'h0);
        drive(1, 0, 0, 16'h0, 8'h0);
        repeat (6) @(negedge clk25);

        // Timeout: m1 write never acknowledged.
        do_reset();
        ack_en = 1'b0;
        drive(1, 1, 1, 16'hE000, 8'hA5);
        for (k = 0; k < 10 && !ctl_req; k++) @(negedge clk25);
        chk("tmo_addr", ctl_addr, 16'hE000);
        chk("tmo_we", ctl_we, 1);
        chk("tmo_wdata", ctl_wdata, 8'hA5);
        n = 0;
        for (k = 0; k < 400 && ctl_req; k++) begin
            n++;
            @(negedge clk25);
        end
        chk("tmo_len", n, 255);
        chk("tmo_req_drop", ctl_req, 0);
        chk("tmo_ack", m1_ack, 1);
        chk("tmo_rdata", m1_rdata, 8'hFF);
        chk("tmo_err", timeout_err, 1);
        drive(1, 0, 0, 16'h0, 8'h0);
        @(negedge clk25);
        chk("tmo_ack_width", m1_ack, 0);
        ack_en = 1'b1; ctl_lat = 2;
        drive(0, 1, 0, 16'h0300, 8'h00);
        for (k = 0; k < 30 && !m0_ack; k++) @(negedge clk25);
        chk("post_tmo_ack", m0_ack, 1);
        chk("post_tmo_data", m0_rdata, 8'h5A);
        drive(0, 0, 0, 16'h0, 8'h0);
        @(negedge clk25);
        chk("tmo_err_sticky", timeout_err, 1);

        // Asynchronous reset in the middle of a GRANT0.
        ack_en = 1'b0;
        drive(0, 1, 0, 16'h0400, 8'h00);
        for (k = 0; k < 10 && !ctl_req; k++) @(negedge clk25);
        chk("rst_pre_addr", ctl_addr, 16'h0400);
        #10;
        rst_n = 1'b0;
        drive(0, 0, 0, 16'h0, 8'h0);
        #1;
        chk_zero_outs("midrst");
        @(negedge clk25);
        rst_n = 1'b1;
        seen = 1'b0;
        for (k = 0; k < 4; k++) begin
            @(negedge clk25);
            if (m0_ack) seen = 1'b1;
        end
        chk("rst_no_ack", seen, 0);
        ack_en = 1'b1;
        drive(0, 1, 0, 16'h0500, 8'h00);
        drive(1, 1, 0, 16'h0600, 8'h00);
        for (k = 0; k < 10 && !ctl_req; k++) @(negedge clk25);
        chk("rst_first_grant", ctl_addr, 16'h0500);
        for (k = 0; k < 20 && !m0_ack; k++) @(negedge clk25);
        chk("rst_m0_done", m0_ack, 1);
        drive(0, 0, 0, 16'h0, 8'h0);
        for (k = 0; k < 20 && !m1_ack; k++) @(negedge clk25);
        chk("rst_m1_done", m1_ack, 1);
        chk("rst_m1_data", m1_rdata, init_val(16'h0600));
        drive(1, 0, 0, 16'h0, 8'h0);

        // Randomized traffic on both ports with refresh interleaving.
        do_reset();
        rand_lat = 1'b1; ctl_lat = 2;
        busy[0] = 0; busy[1] = 0;
        done_cnt = 0; ref_rises = 0; prev_req = 0; prev_ack = 0; prev_ref = 0;
        for (int c = 0; c < 1250; c++) begin
            @(negedge clk25);
            chk("excl_req_ref", ctl_req & ctl_ref, 0);
            if (prev_req && prev_ack) chk("rnd_gap", ctl_req, 0);
            if (ctl_ref && !prev_ref) begin
                ref_rises++;
                chk("ref_timing", ((cyc % 390) >= 1) && ((cyc % 390) <= 10), 1);
            end
            prev_req = ctl_req; prev_ack = ctl_ack; prev_ref = ctl_ref;
            for (int p = 0; p < 2; p++) begin
                ak = (p == 0) ? m0_ack : m1_ack;
                rd = (p == 0) ? m0_rdata : m1_rdata;
                if (ak) begin
                    chk("ack_owner", busy[p], 1);
                    if (!pwe[p]) chk("rnd_rdata", rd, pexp[p]);
                    busy[p] = 0;
                    done_cnt++;
                    drive(p, 0, 0, 16'h0, 8'h0);
                end
                if (c < 1200 && busy[p] == 0 && $urandom_range(0, 7) != 0) begin
                    pwe[p] = 1'($urandom_range(0, 1));
                    pa[p]  = ((p == 0) ? 16'h1000 : 16'h2000) | 16'($urandom_range(0, 15));
                    pd[p]  = 8'($urandom);
                    if (pwe[p]) ref_mem[pa[p]] = pd[p];
                    else pexp[p] = model_rd(pa[p]);
                    busy[p] = 1;
                    drive(p, 1, pwe[p], pa[p], pd[p]);
                end
            end
        end
        chk("rnd_drained", busy[0] + busy[1], 0);
        chk("rnd_progress", done_cnt > 200, 1);
        chk("ref_count", ref_rises >= 2, 1);
        chk("rnd_no_timeout", timeout_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
